mod_sub_stream: RTL and testbench

Streaming modular subtractor for the NTT datapath: computes result = (a − b) mod Q for Q = 3329 on a valid/ready stream. It is the inverse-direction companion of the combinational modular adder and feeds the difference leg of the inverse (Gentleman–Sande) butterfly. It uses a 2-stage pipeline with full backpressure and a completed-result counter.

---
 rtl/mod_sub_stream.sv | 92 +++++++++
 tb/tb_mod_sub_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sub_stream.sv
// Streaming modular subtractor: result = (a - b) mod Q on a valid/ready stream,
// two-stage pipeline with backpressure. Optional range flag: MOD_SUB_RANGE_CHK_EN.
module mod_sub_stream #(
  parameter int unsigned Q  = 3329,
  parameter int unsigned W  = 12,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  result,
  output logic [CW-1:0] done_cnt
`ifdef MOD_SUB_RANGE_CHK_EN
  ,
  output logic          err
`endif
);

  localparam logic [W-1:0] QW = W'(Q);

  function automatic logic signed [W:0] sub_ext(input logic [W-1:0] x,
                                                input logic [W-1:0] y);
    return $signed({1'b0, x}) - $signed({1'b0, y});
  endfunction

  // A negative difference lies in [-(Q-1), -1], so one conditional +Q suffices.
  function automatic logic [W-1:0] wrap_q(input logic signed [W:0] d);
    logic [W-1:0] lo;
    lo = d[W-1:0];
    return d[W] ? (lo + QW) : lo;
  endfunction

  logic                s1_vld_q, s2_vld_q;
  logic signed [W:0]   s1_diff_q;
  logic [W-1:0]        s2_res_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                s1_adv, s2_adv;
  logic                out_xfer;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = s1_adv && rst_n;
  assign out_xfer = s2_vld_q && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_res_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (s1_adv) s1_vld_q <= in_valid && in_ready;
      if (s2_adv) begin
        s2_vld_q <= s1_vld_q;
        s2_res_q <= wrap_q(s1_diff_q);
      end
      cnt_q <= cnt_d;
    end
  end

  // Stage 1: widened difference, loaded whenever the stage can advance
  always_ff @(posedge clk) begin
    if (s1_adv) s1_diff_q <= sub_ext(a, b);
  end

`ifdef MOD_SUB_RANGE_CHK_EN
  logic s1_flag_q, s2_flag_q;

  // Flag rides alongside its operand pair through both stages
  always_ff @(posedge clk) begin
    if (s1_adv) s1_flag_q <= (a >= QW) || (b >= QW);
    if (s2_adv) s2_flag_q <= s1_flag_q;
  end

  assign err = s2_flag_q && s2_vld_q;
`endif

  assign out_valid = s2_vld_q;
  assign result    = s2_res_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_mod_sub_stream.sv
// Scoreboard bench for mod_sub_stream: directed vectors pushed at acceptance,
// popped and compared by an independent output monitor.
module tb_mod_sub_stream;

  typedef struct packed {
    logic [11:0] r;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] a_s = '0;
  logic [11:0] b_s = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] result;
  logic [15:0] done_cnt;
`ifdef MOD_SUB_RANGE_CHK_EN
  logic        err;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   errs   = 0;
  int   stalls = 0;

  mod_sub_stream #(.Q(3329), .W(12), .CW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .done_cnt  (done_cnt)
`ifdef MOD_SUB_RANGE_CHK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Output monitor: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_output: got result %0d, expected no output", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (result !== e.r) begin
          errs++;
          $display("FAIL sb_result: got %0d, expected %0d", result, e.r);
        end
`ifdef MOD_SUB_RANGE_CHK_EN
        checks++;
        if (err !== e.e) begin
          errs++;
          $display("FAIL sb_err: got %0d, expected %0d", err, e.e);
        end
`endif
      end
    end
  end

  // Present a pair, wait (bounded) for acceptance, optionally record expectation.
  task automatic send(input logic [11:0] av, input logic [11:0] bv,
                      input logic [11:0] er, input bit push, input bit ee);
    int  waitc;
    bit  acc;
    exp_t e;
    a_s = av;
    b_s = bv;
    in_valid = 1'b1;
    waitc = 0;
    acc = 1'b0;
    while (!acc && waitc <= 40) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else begin
        waitc++;
        stalls++;
      end
    end
    if (!acc) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected acceptance", waitc);
    end else if (push) begin
      e.r = er;
      e.e = ee;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] cnt0;
    int          st0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_done_cnt", done_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: result visible after the second register stage
    send(12'd5, 12'd0, 12'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_s1_only_out_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_result", result, 5);
    @(posedge clk);
    #1;
    chk("lat_done_cnt", done_cnt, 1);

    // Wrap-around corners
    send(12'd0,    12'd1,    12'd3328, 1'b1, 1'b0);
    send(12'd0,    12'd3328, 12'd1,    1'b1, 1'b0);
    send(12'd3328, 12'd3328, 12'd0,    1'b1, 1'b0);
    send(12'd3328, 12'd0,    12'd3328, 1'b1, 1'b0);
    drain();
    chk("corner_done_cnt", done_cnt, 5);

    // Back-to-back stream, (i - 2i) mod Q = (Q - i) mod Q
    cnt0 = done_cnt;
    st0  = stalls;
    for (int i = 0; i < 100; i++)
      send(12'(i), 12'(2 * i), 12'((3329 - i) % 3329), 1'b1, 1'b0);
    chk("stream_stalls", stalls - st0, 0);
    drain();
    chk("stream_done_delta", 32'(done_cnt - cnt0), 100);

    // Backpressure: fill both stages, third pair must wait
    out_ready = 1'b0;
    send(12'd10, 12'd3,  12'd7,    1'b1, 1'b0);
    send(12'd20, 12'd30, 12'd3319, 1'b1, 1'b0);
    a_s = 12'd100;
    b_s = 12'd200;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result_stable", result, 7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    send(12'd100, 12'd200, 12'd3229, 1'b1, 1'b0);
    drain();
    chk("bp_done_cnt", done_cnt, 108);

    // Reset with both stages occupied
    out_ready = 1'b0;
    send(12'd1, 12'd2, 12'd0, 1'b0, 1'b0);
    send(12'd3, 12'd4, 12'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("in_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_done_cnt", done_cnt, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(12'd7, 12'd9, 12'd3327, 1'b1, 1'b0);
    drain();
    chk("post_rst_done_cnt", done_cnt, 1);

`ifdef MOD_SUB_RANGE_CHK_EN
    send(12'd3329, 12'd0, 12'd3329, 1'b1, 1'b1);
    send(12'd1,    12'd1, 12'd0,    1'b1, 1'b0);
    drain();
    chk("rc_done_cnt", done_cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
